// File: rtl/ins_mem_pkg.sv
// Shared definitions for the instruction fetch memory: FSM state encoding and
// the default fill pattern written after reset or reinit.
package ins_mem_pkg;

  typedef enum logic {StInit, StRun} state_e;

  // Word i of the default image is i*256 + fill_lo; callers truncate to DATA_W.
  function automatic logic [63:0] fill_word(input logic [31:0] idx, input logic [31:0] fill_lo);
    return {24'd0, idx, 8'd0} + {32'd0, fill_lo};
  endfunction

endpackage

// File: rtl/ins_ram_1r1w.sv
// Simple dual-port storage: synchronous write, synchronous read-first read,
// no reset on the array or the read register.
module ins_ram_1r1w #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both in one block with non-blocking writes: a same-address read sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ins_fetch_mem.sv
// Instruction memory with an INIT/RUN controller: fills a default image after
// reset or reinit, then serves valid/ready reads and range-checked program writes.
module ins_fetch_mem
  import ins_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned FILL_LO = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              init_done
);

  // One extra bit so DEPTH == 2**ADDR_W compares without wrap-around.
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              wr_err_q, wr_err_d;

  logic              rd_in_range, wr_in_range;
  logic              run_ok, rd_accept, wr_accept;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign rd_in_range = {1'b0, rd_addr} < DepthExt;
  assign wr_in_range = {1'b0, wr_addr} < DepthExt;

  // reinit takes priority over any read or write offered in the same cycle.
  assign run_ok    = (state_q == StRun) && !reinit;
  assign rd_accept = run_ok && rd_req && (!rd_valid_q || rd_ready);
  assign wr_accept = run_ok && wr_en && wr_in_range;
  assign ram_re    = rd_accept && rd_in_range;

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    rd_valid_d = rd_valid_q;
    rd_err_d   = rd_err_q;
    wr_err_d   = run_ok && wr_en && !wr_in_range;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr;
    ram_wdata  = wr_data;

    unique case (state_q)
      StInit: begin
        ram_we    = 1'b1;
        ram_waddr = fill_q;
        ram_wdata = DATA_W'(fill_word(32'(fill_q), 32'(FILL_LO)));
        if (reinit) begin
          fill_d = '0;
        end else if (fill_q == LastIdx) begin
          state_d = StRun;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + ADDR_W'(1);
        end
      end
      StRun: begin
        ram_we = wr_accept;
        if (reinit) begin
          state_d    = StInit;
          fill_d     = '0;
          rd_valid_d = 1'b0;
        end else if (rd_accept) begin
          rd_valid_d = 1'b1;
          rd_err_d   = !rd_in_range;
        end else if (rd_ready) begin
          rd_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StInit;
      fill_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  ins_ram_1r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset, so the data path is gated by the flags.
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_data   = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;
  assign wr_err    = wr_err_q;
  assign init_done = (state_q == StRun);

endmodule
